// File: rtl/homography_responder.sv
// rtl/homography_responder.sv - fixed-latency translated pixel lookup responder
module homography_responder #(
    parameter int MEM_LAT = 1,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic [9:0]  query_x,
    input  logic [9:0]  query_y,
    input  logic        start,
    output logic [9:0]  return_x,
    output logic [9:0]  return_y,
    output logic [4:0]  r,
    output logic [5:0]  g,
    output logic [4:0]  b,
    output logic        ready,
    input  logic [10:0] cfg_off_x,
    input  logic [10:0] cfg_off_y,
    input  logic        cfg_load,
    output logic [18:0] mem_addr,
    output logic        mem_rden,
    input  logic [15:0] mem_q,
    output logic [15:0] oob_count
);
    logic [10:0] off_x, off_y, pend_x, pend_y;
    logic        pend;

    logic        v0;
    logic [9:0]  qx0, qy0;
    logic [11:0] sx0, sy0;

    logic        v1, inr1;
    logic [9:0]  qx1, qy1;

    logic        dv   [MEM_LAT];
    logic        dinr [MEM_LAT];
    logic [9:0]  dqx  [MEM_LAT];
    logic [9:0]  dqy  [MEM_LAT];

    logic        inr_c;
    logic [18:0] addr_c;

    // Offsets only change between queries; a load during a burst waits in pend.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            off_x  <= '0;
            off_y  <= '0;
            pend_x <= '0;
            pend_y <= '0;
            pend   <= 1'b0;
        end else if (!start) begin
            if (cfg_load) begin
                off_x <= cfg_off_x;
                off_y <= cfg_off_y;
                pend  <= 1'b0;
            end else if (pend) begin
                off_x <= pend_x;
                off_y <= pend_y;
                pend  <= 1'b0;
            end
        end else if (cfg_load) begin
            pend_x <= cfg_off_x;
            pend_y <= cfg_off_y;
            pend   <= 1'b1;
        end
    end

    always_comb begin
        inr_c  = !sx0[11] && (sx0[10:0] < 11'(H_RES)) &&
                 !sy0[11] && (sy0[10:0] < 11'(V_RES));
        addr_c = 19'(sy0[9:0]) * 19'(H_RES) + 19'(sx0[9:0]);
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            qx0       <= '0;
            qy0       <= '0;
            sx0       <= '0;
            sy0       <= '0;
            v1        <= 1'b0;
            inr1      <= 1'b0;
            qx1       <= '0;
            qy1       <= '0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            oob_count <= '0;
        end else begin
            v0 <= start;
            if (start) begin
                qx0 <= query_x;
                qy0 <= query_y;
                sx0 <= {2'b00, query_x} + {off_x[10], off_x};
                sy0 <= {2'b00, query_y} + {off_y[10], off_y};
            end
            v1       <= v0;
            inr1     <= inr_c;
            qx1      <= qx0;
            qy1      <= qy0;
            mem_rden <= v0 && inr_c;
            mem_addr <= (v0 && inr_c) ? addr_c : '0;
            if (v0 && !inr_c && oob_count != 16'hFFFF)
                oob_count <= oob_count + 16'd1;
        end
    end

    // Sideband rides alongside the memory read so it meets mem_q at the output.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                dv[i]   <= 1'b0;
                dinr[i] <= 1'b0;
                dqx[i]  <= '0;
                dqy[i]  <= '0;
            end
        end else begin
            dv[0]   <= v1;
            dinr[0] <= inr1;
            dqx[0]  <= qx1;
            dqy[0]  <= qy1;
            for (int i = 1; i < MEM_LAT; i++) begin
                dv[i]   <= dv[i-1];
                dinr[i] <= dinr[i-1];
                dqx[i]  <= dqx[i-1];
                dqy[i]  <= dqy[i-1];
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            ready    <= 1'b0;
            return_x <= '0;
            return_y <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            ready <= dv[MEM_LAT-1];
            if (dv[MEM_LAT-1]) begin
                return_x <= dqx[MEM_LAT-1];
                return_y <= dqy[MEM_LAT-1];
                r <= dinr[MEM_LAT-1] ? mem_q[15:11] : 5'd0;
                g <= dinr[MEM_LAT-1] ? mem_q[10:5]  : 6'd0;
                b <= dinr[MEM_LAT-1] ? mem_q[4:0]   : 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_homography_responder.sv
// tb/tb_homography_responder.sv - directed bench for homography_responder
module tb_homography_responder;
    logic        clk_25 = 1'b0;
    logic        rst_n;
    logic [9:0]  query_x, query_y;
    logic        start;
    logic [9:0]  return_x, return_y;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        ready;
    logic [10:0] cfg_off_x, cfg_off_y;
    logic        cfg_load;
    logic [18:0] mem_addr;
    logic        mem_rden;
    logic [15:0] mem_q = 16'h0;
    logic [15:0] oob_count;

    int checks = 0;
    int errors = 0;

    logic        st_a  [32];
    logic [9:0]  qx_a  [32];
    logic [9:0]  qy_a  [32];
    logic        ld_a  [32];
    logic [10:0] ldx_a [32];
    logic [18:0] ea_a  [32];
    logic        in_a  [32];

    homography_responder dut (
        .clk_25(clk_25), .rst_n(rst_n), .query_x(query_x), .query_y(query_y),
        .start(start), .return_x(return_x), .return_y(return_y),
        .r(r), .g(g), .b(b), .ready(ready),
        .cfg_off_x(cfg_off_x), .cfg_off_y(cfg_off_y), .cfg_load(cfg_load),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q),
        .oob_count(oob_count)
    );

    always #5 clk_25 = ~clk_25;

    // Frame buffer model: each word holds the low 16 bits of its own address.
    always @(posedge clk_25) begin
        if (mem_rden) mem_q <= mem_addr[15:0];
    end

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 32; i++) begin
            st_a[i] = 0; qx_a[i] = 0; qy_a[i] = 0; ld_a[i] = 0;
            ldx_a[i] = 0; ea_a[i] = 0; in_a[i] = 0;
        end
    endtask

    task automatic load(input logic [10:0] ox, input logic [10:0] oy);
        cfg_off_x = ox;
        cfg_off_y = oy;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic run(input int len);
        logic [15:0] pix;
        for (int c = 0; c < len + 5; c++) begin
            if (c >= 2 && st_a[c-2]) begin
                chk("mem_rden", 32'(mem_rden), 32'(in_a[c-2]));
                chk("mem_addr", 32'(mem_addr), in_a[c-2] ? 32'(ea_a[c-2]) : 32'd0);
            end
            if (c >= 4 && st_a[c-4]) begin
                pix = in_a[c-4] ? ea_a[c-4][15:0] : 16'h0;
                chk("ready", 32'(ready), 32'd1);
                chk("return_x", 32'(return_x), 32'(qx_a[c-4]));
                chk("return_y", 32'(return_y), 32'(qy_a[c-4]));
                chk("rgb", 32'({r, g, b}), 32'(pix));
            end else begin
                chk("ready_idle", 32'(ready), 32'd0);
            end
            if (c < len) begin
                start   = st_a[c];
                query_x = qx_a[c];
                query_y = qy_a[c];
                if (ld_a[c]) begin
                    cfg_load  = 1'b1;
                    cfg_off_x = ldx_a[c];
                end else begin
                    cfg_load  = 1'b0;
                end
            end else begin
                start    = 1'b0;
                cfg_load = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 0; query_x = 0; query_y = 0;
        cfg_off_x = 0; cfg_off_y = 0; cfg_load = 0;
        tick(); tick();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_rden", 32'(mem_rden), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_ret", 32'({return_x, return_y}), 0);
        chk("rst_rgb", 32'({r, g, b}), 0);
        chk("rst_oob", 32'(oob_count), 0);
        rst_n = 1'b1;
        tick();

        // single query (10,20) -> 20*640+10 = 12810
        clr();
        st_a[0] = 1; qx_a[0] = 10; qy_a[0] = 20; ea_a[0] = 12810; in_a[0] = 1;
        run(1);

        // streaming: 8 queries, gap of 2, then 3 more
        clr();
        for (int c = 0; c < 13; c++) begin
            if (c < 8 || c >= 10) begin
                st_a[c] = 1;
                qx_a[c] = (c < 8) ? 10'(c) : 10'(c - 2);
                ea_a[c] = 19'(qx_a[c]);
                in_a[c] = 1;
            end
        end
        run(13);

        // +5 column offset: 634 -> 639 in range, 636 -> 641 out of range
        load(11'd5, 11'd0);
        clr();
        st_a[0] = 1; qx_a[0] = 634; ea_a[0] = 639; in_a[0] = 1;
        st_a[2] = 1; qx_a[2] = 636; in_a[2] = 0;
        run(3);
        // -3 row offset: row 2 -> -1 out of range, row 3 -> 0 in range
        load(11'd0, 11'h7FD);
        clr();
        st_a[0] = 1; qx_a[0] = 0; qy_a[0] = 2; in_a[0] = 0;
        st_a[1] = 1; qx_a[1] = 7; qy_a[1] = 3; ea_a[1] = 7; in_a[1] = 1;
        run(2);
        chk("oob_two", 32'(oob_count), 2);

        // corner pixel and first column beyond the frame
        load(11'd0, 11'd0);
        clr();
        st_a[0] = 1; qx_a[0] = 639; qy_a[0] = 479; ea_a[0] = 307199; in_a[0] = 1;
        st_a[1] = 1; qx_a[1] = 640; qy_a[1] = 0; in_a[1] = 0;
        st_a[2] = 1; qx_a[2] = 0; qy_a[2] = 480; in_a[2] = 0;
        run(3);
        chk("oob_four", 32'(oob_count), 4);

        // config load mid-burst is deferred until start drops
        clr();
        for (int c = 0; c < 6; c++) begin
            st_a[c] = 1; qx_a[c] = 10'(100 + c); qy_a[c] = 1;
            ea_a[c] = 19'(640 + 100 + c); in_a[c] = 1;
        end
        ld_a[2] = 1; ldx_a[2] = 11'd1;
        st_a[7] = 1; qx_a[7] = 50; qy_a[7] = 1; ea_a[7] = 691; in_a[7] = 1;
        run(8);

        // reset in flight discards queued results
        start = 1; query_x = 1; query_y = 1; tick();
        query_x = 2; tick();
        query_x = 3; rst_n = 1'b0; tick();
        start = 0; rst_n = 1'b1;
        chk("mid_rst_oob", 32'(oob_count), 0);
        chk("mid_rst_ret", 32'({return_x, return_y}), 0);
        chk("mid_rst_rgb", 32'({r, g, b}), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        for (int c = 0; c < 6; c++) begin
            chk("mid_rst_ready", 32'(ready), 0);
            tick();
        end
        // offsets were cleared by reset, so (5,2) maps to 1285
        clr();
        st_a[0] = 1; qx_a[0] = 5; qy_a[0] = 2; ea_a[0] = 1285; in_a[0] = 1;
        run(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
